// File: rtl/morse_pkg.sv
// Shared symbol codes, widths and sequencer state encoding for the Morse front-end.
package morse_pkg;

   localparam logic [1:0] SYM_DOT  = 2'b01;
   localparam logic [1:0] SYM_DASH = 2'b11;
   localparam int         CODE_W   = 10;
   localparam int         NUM_W    = 6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRESS,
      ST_GAP,
      ST_SEND,
      ST_CAPTURE
   } seq_state_t;

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for the raw key level; 2-cycle latency, no flow control.
module key_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/morse_sequencer.sv
// Classifies key presses into dots/dashes, packs a letter code, strobes the decoder and reports the result.
// char_valid follows the final release by GAP_CYCLES+2 edges; key activity during SEND/CAPTURE waits for IDLE.
module morse_sequencer
   import morse_pkg::*;
#(
   parameter int DASH_CYCLES = 4,
   parameter int GAP_CYCLES  = 8,
   parameter int MAX_SYMBOLS = 5,
   parameter int CNT_W       = $clog2(((DASH_CYCLES > GAP_CYCLES) ? DASH_CYCLES : GAP_CYCLES) + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              key_in,
   output logic [CODE_W-1:0] letter_bits,
   output logic              send,
   input  logic [NUM_W-1:0]  letter_num,
   output logic              char_valid,
   output logic [NUM_W-1:0]  char_num,
   output logic              char_err,
   output logic              busy
);

   localparam int                SYM_W    = $clog2(MAX_SYMBOLS + 1);
   localparam logic [CNT_W-1:0]  DASH_LIM = CNT_W'(DASH_CYCLES);
   localparam logic [CNT_W-1:0]  GAP_LIM  = CNT_W'(GAP_CYCLES);
   localparam logic [SYM_W-1:0]  SYM_LIM  = SYM_W'(MAX_SYMBOLS);

   logic key_s;

   seq_state_t        state_q, state_d;
   logic [CNT_W-1:0]  press_cnt_q, press_cnt_d;
   logic [CNT_W-1:0]  gap_cnt_q, gap_cnt_d;
   logic [SYM_W-1:0]  sym_cnt_q, sym_cnt_d;
   logic [CODE_W-1:0] code_q, code_d;
   logic              ovf_q, ovf_d;
   logic              send_q, send_d;
   logic [NUM_W-1:0]  num_hold_q, num_hold_d;
   logic              char_valid_q, char_valid_d;
   logic [NUM_W-1:0]  char_num_q, char_num_d;
   logic              char_err_q, char_err_d;
   logic [1:0]        sym;

   key_sync u_key_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (key_in),
      .q_o   (key_s)
   );

   always_comb begin
      state_d      = state_q;
      press_cnt_d  = press_cnt_q;
      gap_cnt_d    = gap_cnt_q;
      sym_cnt_d    = sym_cnt_q;
      code_d       = code_q;
      ovf_d        = ovf_q;
      send_d       = 1'b0;
      num_hold_d   = num_hold_q;
      char_valid_d = 1'b0;
      char_num_d   = char_num_q;
      char_err_d   = char_err_q;
      sym          = SYM_DOT;

      case (state_q)
         ST_IDLE: begin
            if (key_s) begin
               state_d     = ST_PRESS;
               press_cnt_d = CNT_W'(1);
            end
         end
         ST_PRESS: begin
            if (key_s) begin
               if (press_cnt_q < DASH_LIM) press_cnt_d = press_cnt_q + 1'b1;
            end else begin
               sym = (press_cnt_q >= DASH_LIM) ? SYM_DASH : SYM_DOT;
               // Symbols beyond capacity are dropped but poison the letter.
               if (sym_cnt_q < SYM_LIM) begin
                  code_d    = {code_q[CODE_W-3:0], sym};
                  sym_cnt_d = sym_cnt_q + 1'b1;
               end else begin
                  ovf_d = 1'b1;
               end
               state_d   = ST_GAP;
               gap_cnt_d = CNT_W'(1);
            end
         end
         ST_GAP: begin
            if (key_s) begin
               state_d     = ST_PRESS;
               press_cnt_d = CNT_W'(1);
            end else if (gap_cnt_q == GAP_LIM) begin
               state_d = ST_SEND;
               send_d  = 1'b1;
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end
         ST_SEND: begin
            // Decoder has had a full cycle since the send edge to settle.
            num_hold_d = letter_num;
            state_d    = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            char_num_d   = ovf_q ? '0 : num_hold_q;
            char_err_d   = ovf_q;
            char_valid_d = 1'b1;
            code_d       = '0;
            sym_cnt_d    = '0;
            ovf_d        = 1'b0;
            state_d      = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         press_cnt_q  <= '0;
         gap_cnt_q    <= '0;
         sym_cnt_q    <= '0;
         code_q       <= '0;
         ovf_q        <= 1'b0;
         send_q       <= 1'b0;
         num_hold_q   <= '0;
         char_valid_q <= 1'b0;
         char_num_q   <= '0;
         char_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         press_cnt_q  <= press_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
         sym_cnt_q    <= sym_cnt_d;
         code_q       <= code_d;
         ovf_q        <= ovf_d;
         send_q       <= send_d;
         num_hold_q   <= num_hold_d;
         char_valid_q <= char_valid_d;
         char_num_q   <= char_num_d;
         char_err_q   <= char_err_d;
      end
   end

   assign letter_bits = code_q;
   assign send        = send_q;
   assign char_valid  = char_valid_q;
   assign char_num    = char_num_q;
   assign char_err    = char_err_q;
   assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_morse_sequencer.sv
// Directed bench for morse_sequencer with a behavioural letter decoder.
module tb_morse_sequencer;

   logic       clk;
   logic       rst_n;
   logic       key_in;
   logic [9:0] letter_bits;
   logic       send;
   logic [5:0] letter_num;
   logic       char_valid;
   logic [5:0] char_num;
   logic       char_err;
   logic       busy;

   morse_sequencer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_in      (key_in),
      .letter_bits (letter_bits),
      .send        (send),
      .letter_num  (letter_num),
      .char_valid  (char_valid),
      .char_num    (char_num),
      .char_err    (char_err),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [5:0] decode(input logic [9:0] c);
      case (c)
         10'b0000000111: decode = 6'd1;
         10'b0000000001: decode = 6'd5;
         10'b0000000011: decode = 6'd20;
         10'b1111111111: decode = 6'd36;
         10'b0101010101: decode = 6'd31;
         default:        decode = 6'd0;
      endcase
   endfunction

   always_comb letter_num = decode(letter_bits);

   int         cyc = 0;
   int         send_cnt = 0;
   int         cv_cnt = 0;
   int         send_cyc = 0;
   int         cv_cyc = 0;
   logic [9:0] send_bits = '0;
   logic [5:0] cv_num = '0;
   logic       cv_err = 1'b0;
   logic [5:0] cv_hist [8];
   logic [9:0] send_hist [8];

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (send === 1'b1) begin
         send_hist[send_cnt % 8] = letter_bits;
         send_cnt  = send_cnt + 1;
         send_cyc  = cyc;
         send_bits = letter_bits;
      end
      if (char_valid === 1'b1) begin
         cv_hist[cv_cnt % 8] = char_num;
         cv_cnt = cv_cnt + 1;
         cv_cyc = cyc;
         cv_num = char_num;
         cv_err = char_err;
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic press(input int n);
      key_in = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic rel(input int n);
      key_in = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_cv(input int target, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (cv_cnt >= target) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (cv_cnt >= target) ok = 1'b1;
   endtask

   typedef struct {
      string      name;
      int         nsym;
      int         gap;
      int         plen [6];
      logic [9:0] exp_bits;
      logic [5:0] exp_num;
      logic       exp_err;
   } vec_t;

   vec_t vecs [7];

   task automatic run_letter(input vec_t v);
      int sb;
      int cb;
      bit ok;
      sb = send_cnt;
      cb = cv_cnt;
      for (int i = 0; i < v.nsym; i++) begin
         press(v.plen[i]);
         rel((i == v.nsym - 1) ? 1 : v.gap);
      end
      wait_cv(cb + 1, 60, ok);
      check({v.name, " char_valid seen"}, 32'(ok), 32'd1);
      rel(4);
      check({v.name, " send pulses"}, 32'(send_cnt - sb), 32'd1);
      check({v.name, " char_valid pulses"}, 32'(cv_cnt - cb), 32'd1);
      check({v.name, " letter_bits at send"}, 32'(send_bits), 32'(v.exp_bits));
      check({v.name, " char_num"}, 32'(cv_num), 32'(v.exp_num));
      check({v.name, " char_err"}, 32'(cv_err), 32'(v.exp_err));
      check({v.name, " send to char_valid"}, 32'(cv_cyc - send_cyc), 32'd2);
      check({v.name, " char_num held"}, 32'(char_num), 32'(v.exp_num));
      check({v.name, " idle busy"}, 32'(busy), 32'd0);
      check({v.name, " code cleared"}, 32'(letter_bits), 32'd0);
   endtask

   initial begin
      int  sb;
      int  cb;
      bit  ok;

      vecs[0] = '{name:"A",        nsym:2, gap:2, plen:'{2, 6, 0, 0, 0, 0}, exp_bits:10'b0000000111, exp_num:6'd1,  exp_err:1'b0};
      vecs[1] = '{name:"E3",       nsym:1, gap:2, plen:'{3, 0, 0, 0, 0, 0}, exp_bits:10'b0000000001, exp_num:6'd5,  exp_err:1'b0};
      vecs[2] = '{name:"T4",       nsym:1, gap:2, plen:'{4, 0, 0, 0, 0, 0}, exp_bits:10'b0000000011, exp_num:6'd20, exp_err:1'b0};
      vecs[3] = '{name:"ZERO",     nsym:5, gap:2, plen:'{5, 5, 5, 5, 5, 0}, exp_bits:10'b1111111111, exp_num:6'd36, exp_err:1'b0};
      vecs[4] = '{name:"A_GAP8",   nsym:2, gap:8, plen:'{1, 4, 0, 0, 0, 0}, exp_bits:10'b0000000111, exp_num:6'd1,  exp_err:1'b0};
      vecs[5] = '{name:"OVF",      nsym:6, gap:2, plen:'{1, 1, 1, 1, 1, 1}, exp_bits:10'b0101010101, exp_num:6'd0,  exp_err:1'b1};
      vecs[6] = '{name:"E_AFTER",  nsym:1, gap:2, plen:'{2, 0, 0, 0, 0, 0}, exp_bits:10'b0000000001, exp_num:6'd5,  exp_err:1'b0};

      rst_n  = 1'b0;
      key_in = 1'b0;
      repeat (3) @(negedge clk);
      check("reset letter_bits", 32'(letter_bits), 32'd0);
      check("reset send", 32'(send), 32'd0);
      check("reset char_valid", 32'(char_valid), 32'd0);
      check("reset char_num", 32'(char_num), 32'd0);
      check("reset char_err", 32'(char_err), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      rel(3);

      for (int i = 0; i < 7; i++) run_letter(vecs[i]);

      // Reset in the middle of the fourth press of a letter.
      sb = send_cnt;
      cb = cv_cnt;
      for (int i = 0; i < 3; i++) begin
         press(2);
         rel(2);
      end
      press(4);
      check("pre-reset busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("midreset letter_bits", 32'(letter_bits), 32'd0);
      check("midreset send", 32'(send), 32'd0);
      check("midreset char_valid", 32'(char_valid), 32'd0);
      check("midreset char_num", 32'(char_num), 32'd0);
      check("midreset char_err", 32'(char_err), 32'd0);
      check("midreset busy", 32'(busy), 32'd0);
      key_in = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      rel(30);
      check("aborted letter send", 32'(send_cnt - sb), 32'd0);
      check("aborted letter char_valid", 32'(cv_cnt - cb), 32'd0);
      run_letter(vecs[1]);

      // E, then a press whose synchronized level rises while SEND is active.
      sb = send_cnt;
      cb = cv_cnt;
      press(2);
      rel(9);
      press(6);
      rel(1);
      wait_cv(cb + 2, 80, ok);
      check("b2b both letters seen", 32'(ok), 32'd1);
      rel(4);
      check("b2b send pulses", 32'(send_cnt - sb), 32'd2);
      check("b2b char_valid pulses", 32'(cv_cnt - cb), 32'd2);
      check("b2b first code", 32'(send_hist[sb % 8]), 32'(10'b0000000001));
      check("b2b first num", 32'(cv_hist[cb % 8]), 32'd5);
      check("b2b second code", 32'(send_hist[(sb + 1) % 8]), 32'(10'b0000000011));
      check("b2b second num", 32'(cv_hist[(cb + 1) % 8]), 32'd20);
      check("b2b idle busy", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
